// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer clocked by clkin. The divider's slow square
// wave is synchronized and edge-detected to produce one tick per rising edge.
module countdown_timer #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] INIT_TENS   = 4'd6,
    parameter logic [3:0] INIT_ONES   = 4'd0
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t                 state, nxt_state;
    logic [3:0]             nxt_tens, nxt_ones;
    logic                   nxt_exp;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   tick;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Edge pulse is registered so a rise sampled at edge k decrements at k+3.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], slow_clk};
            prev <= sync[SYNC_STAGES-1];
            tick <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tens    <= INIT_TENS;
            ones    <= INIT_ONES;
            expired <= 1'b0;
        end else begin
            state   <= nxt_state;
            tens    <= nxt_tens;
            ones    <= nxt_ones;
            expired <= nxt_exp;
        end
    end

    logic is_zero;
    assign is_zero = (tens == 4'd0) && (ones == 4'd0);

    always_comb begin
        nxt_state = state;
        nxt_tens  = tens;
        nxt_ones  = ones;
        nxt_exp   = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (load) begin
                    nxt_tens = clamp9(load_tens);
                    nxt_ones = clamp9(load_ones);
                end else if (start && !is_zero) begin
                    nxt_state = RUN;
                end
            end
            RUN: begin
                if (pause) begin
                    nxt_state = PAUSE;
                end else if (tick && !is_zero) begin
                    if (ones != 4'd0) begin
                        nxt_ones = ones - 4'd1;
                    end else begin
                        nxt_ones = 4'd9;
                        nxt_tens = tens - 4'd1;
                    end
                    if (tens == 4'd0 && ones == 4'd1) begin
                        nxt_state = DONE;
                        nxt_exp   = 1'b1;
                    end
                end
            end
            DONE: begin
                if (load) begin
                    nxt_tens  = clamp9(load_tens);
                    nxt_ones  = clamp9(load_ones);
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        running  = (state == RUN);
        done     = (state == DONE);
        seg_tens = seg7(tens);
        seg_ones = seg7(ones);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer: an integer-count reference model with
// a sampled-history tick delay, compared every clkin cycle.
module tb_countdown_timer;

    logic       clkin = 1'b0;
    logic       rst = 1'b0;
    logic       slow_clk = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_ones = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens, ones;
    logic [6:0] seg_tens, seg_ones;
    logic       running, done, expired;

    countdown_timer dut (
        .clkin(clkin), .rst(rst), .slow_clk(slow_clk), .load(load),
        .load_tens(load_tens), .load_ones(load_ones), .start(start),
        .pause(pause), .tens(tens), .ones(ones), .seg_tens(seg_tens),
        .seg_ones(seg_ones), .running(running), .done(done), .expired(expired)
    );

    always #5 clkin = ~clkin;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    logic [6:0] segtab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

    int       m_cnt, m_st;
    bit       m_exp;
    bit [3:0] hist;    // slow_clk as sampled at the last four edges, newest in [0]
    int       errs = 0, checks = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    task automatic model_reset();
        m_cnt = 60; m_st = M_IDLE; m_exp = 0; hist = '0;
    endtask

    task automatic model_edge();
        bit tk;
        tk    = hist[2] & ~hist[3];
        hist  = {hist[2:0], slow_clk};
        m_exp = 0;
        case (m_st)
            M_IDLE, M_PAUSE: begin
                if (load) m_cnt = clamp9(load_tens) * 10 + clamp9(load_ones);
                else if (start && m_cnt != 0) m_st = M_RUN;
            end
            M_RUN: begin
                if (pause) m_st = M_PAUSE;
                else if (tk && m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_st = M_DONE; m_exp = 1; end
                end
            end
            default: if (load) begin
                m_cnt = clamp9(load_tens) * 10 + clamp9(load_ones);
                m_st  = M_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        chk("tens", tens, m_cnt / 10);
        chk("ones", ones, m_cnt % 10);
        chk("seg_tens", seg_tens, segtab[m_cnt / 10]);
        chk("seg_ones", seg_ones, segtab[m_cnt % 10]);
        chk("running", running, m_st == M_RUN);
        chk("done", done, m_st == M_DONE);
        chk("expired", expired, m_exp);
    endtask

    task automatic step();
        @(posedge clkin);
        if (!rst) model_reset(); else model_edge();
        #1 check_all();
    endtask

    task automatic cmd_load(input int t, input int o);
        load = 1; load_tens = 4'(t); load_ones = 4'(o); step(); load = 0;
    endtask

    task automatic cmd_start();
        start = 1; step(); start = 0;
    endtask

    task automatic cmd_pause();
        pause = 1; step(); pause = 0;
    endtask

    task automatic pulse();
        slow_clk = 1; repeat (4) step();
        slow_clk = 0; repeat (2) step();
    endtask

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    task automatic async_reset();
        #2 rst = 0;
        #1 model_reset(); check_all();
        repeat (2) step();
        rst = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) step();
        rst = 1;
        repeat (2) step();
        chk("rst_seg_tens", seg_tens, 7'b1111101);
        chk("rst_seg_ones", seg_ones, 7'b0111111);

        // Load 03, run down; each change lands exactly three edges after the rise.
        cmd_load(0, 3);
        cmd_start();
        slow_clk = 1; repeat (3) step();
        chk("lat_before", ones, 3);
        step();
        chk("lat_after", ones, 2);
        slow_clk = 0; repeat (2) step();
        pulse(); pulse();
        chk("done_hi", done, 1);
        pulse();
        chk("stay_00", ones, 0);

        // Borrow across digits.
        cmd_load(1, 0); cmd_start(); pulse();
        chk("borrow_t", tens, 0); chk("borrow_o", ones, 9);
        pulse();
        chk("next_o", ones, 8);

        // Pause coinciding with a tick wins.
        cmd_pause(); cmd_load(0, 5); cmd_start();
        slow_clk = 1; repeat (3) step();
        pause = 1; step(); pause = 0;
        slow_clk = 0; repeat (2) step();
        chk("pause_hold", ones, 5);
        pulse();
        cmd_start(); pulse();
        chk("resume_dec", ones, 4);

        // Load handling per state, with clamping.
        cmd_load(12, 12);
        chk("run_load_ign", ones, 4);
        cmd_pause(); cmd_load(12, 12);
        chk("pause_load", tens * 10 + ones, 99);
        cmd_load(0, 1); cmd_start(); pulse();
        cmd_load(1, 2);
        chk("done_load", tens * 10 + ones, 12);
        chk("done_to_idle", done, 0);

        // Reset mid-RUN with slow_clk high; the post-release tick is ignored in IDLE.
        cmd_load(3, 7); cmd_start();
        slow_clk = 1; step();
        async_reset();
        repeat (6) step();
        chk("post_rst", tens * 10 + ones, 60);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) slow_clk = ~slow_clk;
            load      = ($urandom_range(15) == 0);
            load_tens = 4'($urandom_range(15));
            load_ones = 4'($urandom_range(15));
            start     = ($urandom_range(7) == 0);
            pause     = ($urandom_range(24) == 0);
            if ($urandom_range(399) == 0) async_reset();
            step();
        end
        load = 0; start = 0; pause = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
